// File: rtl/core_pkg.sv
// Shared register-index types and stall-cause encoding for the issue hazard logic.
package core_pkg;

  localparam int NREG  = 16;
  localparam int REG_W = $clog2(NREG);

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    NONE,
    RAW,
    WAW,
    CAP,
    LSU,
    WPORT
  } stall_cause_t;

endpackage

// File: rtl/ld_scoreboard.sv
// Load scoreboard: per-register pending bits plus the count of loads in flight.
// A return that matches nothing saturates quietly; simulation flags it.
module ld_scoreboard
  import core_pkg::*;
#(
  parameter int NREG   = core_pkg::NREG,
  parameter int MAX_LD = 2,
  parameter int RW     = $clog2(NREG),
  parameter int CW     = $clog2(MAX_LD + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_fire,
  input  logic [RW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [RW-1:0]   clr_idx,
  output logic [NREG-1:0] pending,
  output logic [CW-1:0]   outstanding
);

  logic [NREG-1:0] pending_reg, pending_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  // x0 never tracks; a clear to the same index as a set takes precedence.
  assign pending_next[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_bit
      logic clr_hit, set_hit;
      assign clr_hit = clr_en && (clr_idx == RW'(gi));
      assign set_hit = ld_fire && (set_idx == RW'(gi)) && !clr_hit;
      assign pending_next[gi] = set_hit | (pending_reg[gi] & ~clr_hit);
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (ld_fire && !clr_en)
      cnt_next = cnt_reg + CW'(1);
    else if (!ld_fire && clr_en && cnt_reg != '0)
      cnt_next = cnt_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign pending     = pending_reg;
  assign outstanding = cnt_reg;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && clr_en)
      assert (cnt_reg != '0 && (clr_idx == '0 || pending_reg[clr_idx]));
  end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Issue hazard control: RAW/WAW/capacity/LSU/write-port stalls, load bypass, write arbitration.
// Define HAZARD_PERF_EN to add the stall_cnt and ld_bypass_cnt performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int NREG   = core_pkg::NREG,
  parameter int MAX_LD = 2,
  parameter int RW     = $clog2(NREG),
  parameter int CW     = $clog2(MAX_LD + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            is_br_op,
  input  logic            is_alu_op,
  input  logic            is_ls_op,
  input  logic            is_load,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  input  logic [RW-1:0]   rd,
  input  logic            ls_load_ready,
  input  logic [RW-1:0]   ld_rd,
  input  logic            lsu_ready,
  output logic            issue_stall,
  output logic            lsu_en,
  output logic            rs1_ld_bypass,
  output logic            rs2_ld_bypass,
  output logic            reg_we,
  output logic [RW-1:0]   rd_mux,
  output logic [CW-1:0]   ld_outstanding,
  output logic [NREG-1:0] sb_pending
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     ld_bypass_cnt
`endif
);

  logic         is_ld, reads_ops, rd_nz, fire;
  logic         raw_hit, waw_hit, cap_hit, lsu_hit, wport_hit;
  stall_cause_t stall_cause;

  assign is_ld     = is_ls_op & is_load;
  assign reads_ops = is_br_op | is_alu_op | is_ls_op;
  assign rd_nz     = (rd != '0);

  assign rs1_ld_bypass = ls_load_ready && (rs1 == ld_rd) && (rs1 != '0);
  assign rs2_ld_bypass = ls_load_ready && (rs2 == ld_rd) && (rs2 != '0);

  // WAW looks only at the registered scoreboard, so a same-cycle return still costs a cycle.
  assign raw_hit   = reads_ops && ((sb_pending[rs1] && !rs1_ld_bypass) ||
                                   (sb_pending[rs2] && !rs2_ld_bypass));
  assign waw_hit   = (is_alu_op | is_ld) && rd_nz && sb_pending[rd];
  assign cap_hit   = is_ld && (ld_outstanding == CW'(MAX_LD)) && !ls_load_ready;
  assign lsu_hit   = is_ls_op && !lsu_ready;
  assign wport_hit = is_alu_op && rd_nz && ls_load_ready;

  always_comb begin
    stall_cause = NONE;
    if (raw_hit)        stall_cause = RAW;
    else if (waw_hit)   stall_cause = WAW;
    else if (cap_hit)   stall_cause = CAP;
    else if (lsu_hit)   stall_cause = LSU;
    else if (wport_hit) stall_cause = WPORT;
  end

  assign issue_stall = issue_valid & (raw_hit | waw_hit | cap_hit | lsu_hit | wport_hit);
  assign fire        = issue_valid & ~issue_stall;
  assign lsu_en      = fire & is_ls_op;

  assign rd_mux = ls_load_ready ? ld_rd : rd;
  assign reg_we = (ls_load_ready | (fire & is_alu_op & rd_nz)) & (rd_mux != '0);

  ld_scoreboard #(
    .NREG   (NREG),
    .MAX_LD (MAX_LD),
    .RW     (RW),
    .CW     (CW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_fire     (fire & is_ld),
    .set_idx     (rd),
    .clr_en      (ls_load_ready),
    .clr_idx     (ld_rd),
    .pending     (sb_pending),
    .outstanding (ld_outstanding)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt     <= '0;
      ld_bypass_cnt <= '0;
    end else begin
      if (issue_stall)
        stall_cnt <= stall_cnt + 32'd1;
      if (fire && (rs1_ld_bypass || rs2_ld_bypass))
        ld_bypass_cnt <= ld_bypass_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n)
      assert (issue_stall == (issue_valid && stall_cause != NONE));
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a queue-based LSU model.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int NREG   = 16;
  localparam int MAX_LD = 2;
  localparam int RW     = 4;
  localparam int CW     = 2;

  logic            clk, rst_n;
  logic            issue_valid, is_br_op, is_alu_op, is_ls_op, is_load;
  logic [RW-1:0]   rs1, rs2, rd, ld_rd, rd_mux;
  logic            ls_load_ready, lsu_ready;
  logic            issue_stall, lsu_en, rs1_ld_bypass, rs2_ld_bypass, reg_we;
  logic [CW-1:0]   ld_outstanding;
  logic [NREG-1:0] sb_pending;
`ifdef HAZARD_PERF_EN
  logic [31:0]     stall_cnt, ld_bypass_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.NREG(NREG), .MAX_LD(MAX_LD)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .is_br_op(is_br_op),
    .is_alu_op(is_alu_op), .is_ls_op(is_ls_op), .is_load(is_load),
    .rs1(rs1), .rs2(rs2), .rd(rd), .ls_load_ready(ls_load_ready), .ld_rd(ld_rd),
    .lsu_ready(lsu_ready), .issue_stall(issue_stall), .lsu_en(lsu_en),
    .rs1_ld_bypass(rs1_ld_bypass), .rs2_ld_bypass(rs2_ld_bypass), .reg_we(reg_we),
    .rd_mux(rd_mux), .ld_outstanding(ld_outstanding), .sb_pending(sb_pending)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .ld_bypass_cnt(ld_bypass_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // op: 0 idle, 1 alu, 2 branch, 3 load, 4 store
  task automatic drive(input int op, input int r1, input int r2, input int d,
                       input bit lr, input int lrd, input bit lrdy);
    issue_valid   = (op != 0);
    is_alu_op     = (op == 1);
    is_br_op      = (op == 2);
    is_ls_op      = (op == 3) || (op == 4);
    is_load       = (op == 3);
    rs1           = RW'(r1);
    rs2           = RW'(r2);
    rd            = RW'(d);
    ls_load_ready = lr;
    ld_rd         = RW'(lrd);
    lsu_ready     = lrdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1'b0, 0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({issue_stall, lsu_en, rs1_ld_bypass, rs2_ld_bypass, reg_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {issue_stall, lsu_en, rs1_ld_bypass, rs2_ld_bypass, reg_we});
    end
    checks++;
    if (sb_pending !== '0 || ld_outstanding !== '0 || rd_mux !== '0) begin
      errors++;
      $display("FAIL reset_state: pending=%h cnt=%0d rd_mux=%0d expected 0/0/0",
               sb_pending, ld_outstanding, rd_mux);
    end
    $display("test_reset done");
  endtask

  task automatic test_raw_bypass();
    drive(3, 0, 0, 5, 1'b0, 0, 1'b1);
    #1;
    checks++;
    if (issue_stall !== 1'b0 || lsu_en !== 1'b1) begin
      errors++;
      $display("FAIL raw_load_fire: stall=%b lsu_en=%b expected 0/1", issue_stall, lsu_en);
    end
    tick();
    drive(1, 5, 0, 0, 1'b0, 0, 1'b1);
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_stall: got %b expected 1", issue_stall);
    end
    drive(1, 5, 0, 0, 1'b1, 5, 1'b1);
    #1;
    checks++;
    if ({rs1_ld_bypass, issue_stall, reg_we} !== 3'b101 || rd_mux !== 4'd5) begin
      errors++;
      $display("FAIL raw_bypass: byp/stall/we=%b rd_mux=%0d expected 101 and 5",
               {rs1_ld_bypass, issue_stall, reg_we}, rd_mux);
    end
    tick();
    drive(0, 0, 0, 0, 1'b0, 0, 1'b1);
    #1;
    checks++;
    if (sb_pending !== '0 || ld_outstanding !== '0) begin
      errors++;
      $display("FAIL raw_clear: pending=%h cnt=%0d expected 0/0", sb_pending, ld_outstanding);
    end
    $display("test_raw_bypass done");
  endtask

  task automatic test_capacity();
    drive(3, 0, 0, 3, 1'b0, 0, 1'b1);
    tick();
    drive(3, 0, 0, 4, 1'b0, 0, 1'b1);
    tick();
    drive(3, 0, 0, 6, 1'b0, 0, 1'b1);
    #1;
    checks++;
    if (issue_stall !== 1'b1 || ld_outstanding !== 2'd2) begin
      errors++;
      $display("FAIL cap_stall: stall=%b cnt=%0d expected 1/2", issue_stall, ld_outstanding);
    end
    tick();
    checks++;
    if (issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL cap_hold: stall=%b expected 1", issue_stall);
    end
    drive(3, 0, 0, 6, 1'b1, 3, 1'b1);
    #1;
    checks++;
    if (issue_stall !== 1'b0 || lsu_en !== 1'b1) begin
      errors++;
      $display("FAIL cap_release: stall=%b lsu_en=%b expected 0/1", issue_stall, lsu_en);
    end
    tick();
    drive(0, 0, 0, 0, 1'b1, 4, 1'b1);
    #1;
    checks++;
    if (ld_outstanding !== 2'd2 || sb_pending !== 16'h0050) begin
      errors++;
      $display("FAIL cap_state: cnt=%0d pending=%h expected 2/0050", ld_outstanding, sb_pending);
    end
    tick();
    drive(0, 0, 0, 0, 1'b1, 6, 1'b1);
    tick();
    drive(0, 0, 0, 0, 1'b0, 0, 1'b1);
    #1;
    checks++;
    if (ld_outstanding !== 2'd0 || sb_pending !== '0) begin
      errors++;
      $display("FAIL cap_drain: cnt=%0d pending=%h expected 0/0", ld_outstanding, sb_pending);
    end
    $display("test_capacity done");
  endtask

  task automatic test_wport();
    drive(3, 0, 0, 2, 1'b0, 0, 1'b1);
    tick();
    drive(1, 0, 0, 7, 1'b1, 2, 1'b1);
    #1;
    checks++;
    if ({issue_stall, reg_we} !== 2'b11 || rd_mux !== 4'd2) begin
      errors++;
      $display("FAIL wport_stall: stall/we=%b rd_mux=%0d expected 11 and 2",
               {issue_stall, reg_we}, rd_mux);
    end
    tick();
    drive(1, 0, 0, 7, 1'b0, 0, 1'b1);
    #1;
    checks++;
    if ({issue_stall, reg_we} !== 2'b01 || rd_mux !== 4'd7) begin
      errors++;
      $display("FAIL wport_fire: stall/we=%b rd_mux=%0d expected 01 and 7",
               {issue_stall, reg_we}, rd_mux);
    end
    tick();
    $display("test_wport done");
  endtask

  task automatic test_waw();
    drive(3, 0, 0, 9, 1'b0, 0, 1'b1);
    tick();
    drive(3, 0, 0, 9, 1'b1, 9, 1'b1);
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall: got %b expected 1", issue_stall);
    end
    tick();
    drive(3, 0, 0, 9, 1'b0, 0, 1'b1);
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL waw_fire: got %b expected 0", issue_stall);
    end
    tick();
    drive(0, 0, 0, 0, 1'b1, 9, 1'b1);
    #1;
    checks++;
    if (sb_pending !== 16'h0200 || ld_outstanding !== 2'd1) begin
      errors++;
      $display("FAIL waw_state: pending=%h cnt=%0d expected 0200/1", sb_pending, ld_outstanding);
    end
    tick();
    $display("test_waw done");
  endtask

  task automatic test_rd0();
    drive(3, 0, 0, 0, 1'b0, 0, 1'b1);
    tick();
    drive(0, 0, 0, 0, 1'b1, 0, 1'b1);
    #1;
    checks++;
    if (sb_pending !== '0 || ld_outstanding !== 2'd1 || reg_we !== 1'b0) begin
      errors++;
      $display("FAIL rd0: pending=%h cnt=%0d we=%b expected 0/1/0",
               sb_pending, ld_outstanding, reg_we);
    end
    tick();
    drive(0, 0, 0, 0, 1'b0, 0, 1'b1);
    $display("test_rd0 done");
  endtask

  task automatic test_random();
    bit [NREG-1:0] m_pend = '0;
    int m_cnt = 0;
    int inflight[$];
    for (int n = 0; n < 400; n++) begin
      int op, r1, r2, d, lrd;
      bit lr, lrdy, b1, b2, raw, waw, cap, lsu, wp, stall, fire, we;
      int mux;
      op   = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 4);
      r1   = $urandom_range(0, 7);
      r2   = $urandom_range(0, 7);
      d    = $urandom_range(0, 7);
      lrdy = $urandom_range(0, 3) != 0;
      lr   = (inflight.size() > 0) && ($urandom_range(0, 1) == 1);
      lrd  = lr ? inflight[0] : $urandom_range(0, 7);
      drive(op, r1, r2, d, lr, lrd, lrdy);
      #1;
      b1    = lr && r1 == lrd && r1 != 0;
      b2    = lr && r2 == lrd && r2 != 0;
      raw   = (op != 0) && ((m_pend[r1] && !b1) || (m_pend[r2] && !b2));
      waw   = (op == 1 || op == 3) && d != 0 && m_pend[d];
      cap   = (op == 3) && m_cnt == MAX_LD && !lr;
      lsu   = (op == 3 || op == 4) && !lrdy;
      wp    = (op == 1) && d != 0 && lr;
      stall = (op != 0) && (raw || waw || cap || lsu || wp);
      fire  = (op != 0) && !stall;
      mux   = lr ? lrd : d;
      we    = (lr || (fire && op == 1 && d != 0)) && mux != 0;
      checks++;
      if ({issue_stall, lsu_en, rs1_ld_bypass, rs2_ld_bypass, reg_we} !==
          {stall, fire && (op == 3 || op == 4), b1, b2, we}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got %b expected %b (op=%0d rs=%0d,%0d rd=%0d ret=%b/%0d)",
                 n, {issue_stall, lsu_en, rs1_ld_bypass, rs2_ld_bypass, reg_we},
                 {stall, fire && (op == 3 || op == 4), b1, b2, we}, op, r1, r2, d, lr, lrd);
      end
      checks++;
      if (rd_mux !== RW'(mux) || ld_outstanding !== CW'(m_cnt) || sb_pending !== m_pend) begin
        errors++;
        $display("FAIL rand_state[%0d]: mux=%0d cnt=%0d pend=%h expected %0d/%0d/%h",
                 n, rd_mux, ld_outstanding, sb_pending, mux, m_cnt, m_pend);
      end
      tick();
      if (lr) begin
        void'(inflight.pop_front());
        if (lrd != 0) m_pend[lrd] = 1'b0;
        m_cnt--;
      end
      if (fire && op == 3) begin
        inflight.push_back(d);
        if (d != 0) m_pend[d] = 1'b1;
        m_cnt++;
      end
    end
    drive(0, 0, 0, 0, 1'b0, 0, 1'b1);
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    drive(3, 0, 0, 3, 1'b0, 0, 1'b1);
    tick();
    drive(3, 0, 0, 4, 1'b0, 0, 1'b1);
    tick();
    drive(0, 0, 0, 0, 1'b0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sb_pending !== '0 || ld_outstanding !== '0) begin
      errors++;
      $display("FAIL async_reset: pending=%h cnt=%0d expected 0/0", sb_pending, ld_outstanding);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0 || ld_bypass_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_perf: stall_cnt=%0d bypass_cnt=%0d expected 0/0",
               stall_cnt, ld_bypass_cnt);
    end
`endif
    tick();
    rst_n = 1'b1;
    #1;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_raw_bypass();
    test_capacity();
    test_wport();
    test_waw();
    test_rd0();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
